// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// The fetch queue carries {pc, instr} pairs from fetch to decode.
package rv_fetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          INSTR_BYTES   = 4;
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush.
// Push and pop may coincide even when full; flush empties it in one cycle.
import rv_fetch_pkg::*;

module fetch_queue #(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t   mem_q [QDEPTH];
    fetch_entry_t   mem_d [QDEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop_ok;
    logic           push_ok;

    assign full  = (count_q == CW'(QDEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Queue state register; reset discards all entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, fetches from a combinational
// instruction memory and hands {pc, instr} to decode via a small queue.
import rv_fetch_pkg::*;

module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready
);

    logic [63:0]  pc_q, pc_d;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t push_data;

    // Handshake decisions; a redirect blocks both fetch and retire.
    always_comb begin
        pop       = ~empty & id_ready & ~redirect;
        push      = ~redirect & (~full | pop);
        push_data = fetch_entry_t'{pc: pc_q, instr: imem_rdata};
    end

    // Next PC: redirect target (word-aligned), else advance on a fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & PC_ALIGN_MASK;
        end else if (push) begin
            pc_d = pc_q + 64'(INSTR_BYTES);
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Decode-side outputs are zeroed while the queue is empty.
    always_comb begin
        imem_addr = pc_q;
        id_valid  = ~empty;
        id_instr  = id_valid ? head.instr : 32'h0;
        id_pc     = id_valid ? head.pc : 64'h0;
    end

endmodule
